// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : btn_pkg
// Brief    : Shared constants and FSM state type for the button event arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

   localparam int N_BTN              = 4;
   localparam int DEB_CYCLES_DEFAULT = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : One button channel: 2-flop synchroniser, debounce, rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic             r_deb_d;
   logic [CNT_W-1:0] r_cnt;

   // r_cnt tracks how long the synchronised level has disagreed with r_deb
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_deb_d <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         if (r_sync2 != r_deb) begin
            if (r_cnt == c_cnt_last) begin
               r_deb <= ~r_deb;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_deb & ~r_deb_d;

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_arbiter
// Brief    : N conditioned buttons, per-channel pending flags, round-robin valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module btn_event_arbiter
   import btn_pkg::*;
#(
   parameter int N          = N_BTN,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int ID_W       = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    btn_in,
   input  logic            evt_ready,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   input  logic            drop_clr,
   output logic [N-1:0]    drop_flag
);

   logic [N-1:0]    w_press;
   logic [N-1:0]    r_pending;
   logic [N-1:0]    r_drop;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] r_evt_id;
   logic [ID_W-1:0] w_winner;
   logic [ID_W-1:0] w_hi_idx;
   logic [ID_W-1:0] w_lo_idx;
   logic            w_hi_any;
   logic            w_any;
   logic            w_load;
   logic [N-1:0]    w_load_mask;
   logic [N-1:0]    w_drop_set;
   btn_state_t      r_state;
   btn_state_t      w_state_nxt;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_chan
         btn_conditioner #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_cond (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (btn_in[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   // Winner is the lowest pending index >= r_rr_ptr, else the lowest pending overall (wrap).
   always_comb begin
      w_any    = 1'b0;
      w_hi_any = 1'b0;
      w_lo_idx = '0;
      w_hi_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_any    = 1'b1;
            w_lo_idx = ID_W'(i);
            if (ID_W'(i) >= r_rr_ptr) begin
               w_hi_any = 1'b1;
               w_hi_idx = ID_W'(i);
            end
         end
      end
      w_winner = w_hi_any ? w_hi_idx : w_lo_idx;
   end

   assign w_load      = w_any & ((r_state == ST_IDLE) | evt_ready);
   assign w_load_mask = w_load ? (N'(1) << w_winner) : '0;
   assign w_drop_set  = w_press & r_pending & ~w_load_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_drop    <= '0;
         r_rr_ptr  <= '0;
         r_evt_id  <= '0;
      end else begin
         // A press arriving in the same cycle as its own load re-arms the flag
         r_pending <= (r_pending & ~w_load_mask) | w_press;
         r_drop    <= (drop_clr ? '0 : r_drop) | w_drop_set;
         if (w_load) begin
            r_evt_id <= w_winner;
            r_rr_ptr <= (w_winner == ID_W'(N - 1)) ? '0 : w_winner + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any) w_state_nxt = ST_FULL;
         ST_FULL: if (evt_ready && !w_any) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      evt_valid = (r_state == ST_FULL);
   end

   assign evt_id    = r_evt_id;
   assign drop_flag = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_arbiter
// Brief    : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_arbiter;

   localparam int N    = 4;
   localparam int DEB  = 4;
   localparam int ID_W = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    btn_in    = '0;
   logic            evt_ready = 1'b0;
   logic            drop_clr  = 1'b0;
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic [N-1:0]    drop_flag;

   int n_cmp  = 0;
   int n_fail = 0;

   btn_event_arbiter #(
      .N          (N),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .drop_clr  (drop_clr),
      .drop_flag (drop_flag)
   );

   always #5 clk = ~clk;

   // Behavioural model: a level is accepted once the last DEB synchronised
   // samples all disagree with it; events follow the pending/round-robin rules.
   logic [31:0]  m_hist [N];
   bit   [N-1:0] m_deb;
   bit   [N-1:0] m_rose;
   bit   [N-1:0] m_pend;
   bit   [N-1:0] m_drop;
   int           m_rr;
   int           m_id;
   bit           m_valid;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_hist[i] = '0;
      m_deb = '0; m_rose = '0; m_pend = '0; m_drop = '0;
      m_rr = 0; m_id = 0; m_valid = 1'b0;
   endtask

   task automatic model_edge();
      int w;
      bit ld, tog;
      bit [N-1:0] p0, dset;
      w = -1;
      for (int j = 0; j < N; j++)
         if (w < 0 && m_pend[(m_rr + j) % N]) w = (m_rr + j) % N;
      ld = (w >= 0) && (!m_valid || evt_ready);
      p0 = m_pend;
      if (ld) begin
         m_id = w; m_rr = (w + 1) % N; m_pend[w] = 1'b0; m_valid = 1'b1;
      end else if (m_valid && evt_ready) begin
         m_valid = 1'b0;
      end
      dset = '0;
      for (int i = 0; i < N; i++) begin
         if (m_rose[i]) begin
            if (p0[i] && !(ld && w == i)) dset[i] = 1'b1;
            m_pend[i] = 1'b1;
         end
      end
      if (drop_clr) m_drop = '0;
      m_drop |= dset;
      for (int i = 0; i < N; i++) begin
         tog = 1'b1;
         for (int b = 1; b <= DEB; b++) if (m_hist[i][b] == m_deb[i]) tog = 1'b0;
         m_rose[i] = tog && !m_deb[i];
         if (tog) m_deb[i] = !m_deb[i];
         m_hist[i] = {m_hist[i][30:0], btn_in[i]};
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic [N-1:0] mask, input int cycles);
      btn_in = mask;
      repeat (cycles) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      btn_in = '0; drop_clr = 1'b0; rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #11;
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
      n_cmp++; if (evt_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
      n_cmp++; if (drop_flag !== '0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0000", drop_flag); end
      n_cmp++; if (dut.r_pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", dut.r_pending); end
      n_cmp++; if (dut.r_rr_ptr !== '0) begin n_fail++; $display("FAIL reset_rr: got %0d expected 0", dut.r_rr_ptr); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      do_reset();
      evt_ready = 1'b1;
      btn_in = 4'b0100;
      for (int s = 1; s <= 20; s++) begin
         step();
         n_cmp++; if (evt_valid !== (s == 8)) begin n_fail++; $display("FAIL latency_valid s=%0d: got %b expected %b", s, evt_valid, (s == 8)); end
         if (s == 8) begin
            n_cmp++; if (evt_id !== 2'd2) begin n_fail++; $display("FAIL latency_id: got %0d expected 2", evt_id); end
         end
      end
      btn_in = '0;
      for (int s = 1; s <= 15; s++) begin
         step();
         n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid s=%0d: got %b expected 0", s, evt_valid); end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      evt_ready = 1'b1;
      btn_in = 4'b0001;
      for (int s = 1; s <= 18; s++) begin
         if (s == 4) btn_in = '0;
         step();
         n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid s=%0d: got %b expected 0", s, evt_valid); end
      end
      n_cmp++; if (dut.r_pending !== '0) begin n_fail++; $display("FAIL glitch_pending: got %b expected 0000", dut.r_pending); end
   endtask

   task automatic test_simultaneous();
      logic [ID_W-1:0] exp_id;
      do_reset();
      evt_ready = 1'b1;
      btn_in = 4'b1011;
      for (int s = 1; s <= 14; s++) begin
         step();
         if (s == 7) begin
            n_cmp++; if (dut.r_pending !== 4'b1011) begin n_fail++; $display("FAIL simul_pending: got %b expected 1011", dut.r_pending); end
         end
         n_cmp++; if (evt_valid !== (s >= 8 && s <= 10)) begin n_fail++; $display("FAIL simul_valid s=%0d: got %b expected %b", s, evt_valid, (s >= 8 && s <= 10)); end
         if (s >= 8 && s <= 10) begin
            exp_id = (s == 8) ? 2'd0 : (s == 9) ? 2'd1 : 2'd3;
            n_cmp++; if (evt_id !== exp_id) begin n_fail++; $display("FAIL simul_id s=%0d: got %0d expected %0d", s, evt_id, exp_id); end
         end
      end
      n_cmp++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL simul_rr: got %0d expected 0", dut.r_rr_ptr); end
      drive('0, 10);
   endtask

   task automatic test_backpressure_drop();
      do_reset();
      evt_ready = 1'b0;
      drive(4'b0010, 8);
      n_cmp++; if ({evt_valid, evt_id} !== 3'b101) begin n_fail++; $display("FAIL bp_first: got v=%b id=%0d expected v=1 id=1", evt_valid, evt_id); end
      drive('0, 8);
      for (int s = 0; s < 10; s++) begin
         step();
         n_cmp++; if ({evt_valid, evt_id} !== 3'b101) begin n_fail++; $display("FAIL bp_hold s=%0d: got v=%b id=%0d expected v=1 id=1", s, evt_valid, evt_id); end
      end
      drive(4'b0010, 8); drive('0, 8);
      n_cmp++; if (dut.r_pending[1] !== 1'b1) begin n_fail++; $display("FAIL bp_pending: got %b expected 1", dut.r_pending[1]); end
      n_cmp++; if (drop_flag !== '0) begin n_fail++; $display("FAIL bp_nodrop: got %b expected 0000", drop_flag); end
      drive(4'b0010, 8); drive('0, 8);
      n_cmp++; if (drop_flag !== 4'b0010) begin n_fail++; $display("FAIL bp_drop: got %b expected 0010", drop_flag); end
      n_cmp++; if (evt_id !== 2'd1) begin n_fail++; $display("FAIL bp_id_stable: got %0d expected 1", evt_id); end
      drop_clr = 1'b1; step(); drop_clr = 1'b0;
      n_cmp++; if (drop_flag !== '0) begin n_fail++; $display("FAIL bp_drop_clr: got %b expected 0000", drop_flag); end
      evt_ready = 1'b1;
      step();
      n_cmp++; if ({evt_valid, evt_id} !== 3'b101) begin n_fail++; $display("FAIL bp_b2b: got v=%b id=%0d expected v=1 id=1", evt_valid, evt_id); end
      step();
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", evt_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      evt_ready = 1'b1;
      drive(4'b0010, 8); drive('0, 8);
      n_cmp++; if (dut.r_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL wrap_rr_pre: got %0d expected 2", dut.r_rr_ptr); end
      btn_in = 4'b0011;
      for (int s = 1; s <= 12; s++) begin
         step();
         n_cmp++; if (evt_valid !== (s == 8 || s == 9)) begin n_fail++; $display("FAIL wrap_valid s=%0d: got %b expected %b", s, evt_valid, (s == 8 || s == 9)); end
         if (s == 8 || s == 9) begin
            n_cmp++; if (evt_id !== ID_W'(s - 8)) begin n_fail++; $display("FAIL wrap_id s=%0d: got %0d expected %0d", s, evt_id, s - 8); end
         end
      end
      n_cmp++; if (dut.r_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL wrap_rr_post: got %0d expected 2", dut.r_rr_ptr); end
      drive('0, 10);
   endtask

   task automatic test_reset_midhandshake();
      do_reset();
      evt_ready = 1'b0;
      drive(4'b1000, 8);
      n_cmp++; if ({evt_valid, evt_id} !== 3'b111) begin n_fail++; $display("FAIL mid_present: got v=%b id=%0d expected v=1 id=3", evt_valid, evt_id); end
      drive('0, 8); drive(4'b0001, 8); drive('0, 8);
      n_cmp++; if (dut.r_pending !== 4'b0001) begin n_fail++; $display("FAIL mid_pending_pre: got %b expected 0001", dut.r_pending); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", evt_valid); end
      n_cmp++; if (evt_id !== '0) begin n_fail++; $display("FAIL mid_id: got %0d expected 0", evt_id); end
      n_cmp++; if (dut.r_pending !== '0) begin n_fail++; $display("FAIL mid_pending: got %b expected 0000", dut.r_pending); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      evt_ready = 1'b1;
      for (int s = 0; s < 20; s++) begin
         step();
         n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after s=%0d: got %b expected 0", s, evt_valid); end
      end
   endtask

   task automatic test_random();
      int hold [N];
      do_reset();
      for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               btn_in[i] = ~btn_in[i];
               hold[i]   = $urandom_range(1, 12);
            end
            hold[i]--;
         end
         evt_ready = ($urandom_range(0, 9) < 7);
         drop_clr  = ($urandom_range(0, 19) == 0);
         step();
         n_cmp++; if (evt_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, evt_valid, m_valid); end
         n_cmp++; if (evt_id !== ID_W'(m_id)) begin n_fail++; $display("FAIL rnd_id c=%0d: got %0d expected %0d", c, evt_id, m_id); end
         n_cmp++; if (drop_flag !== m_drop) begin n_fail++; $display("FAIL rnd_drop c=%0d: got %b expected %b", c, drop_flag, m_drop); end
      end
      btn_in = '0; drop_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_simultaneous();
      test_backpressure_drop();
      test_wrap();
      test_reset_midhandshake();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Conditions N raw push-button inputs and turns each press into one event. Per channel it synchronises the input, debounces it, and detects the rising edge.
- Each pending press is queued as one flag per channel.
- A round-robin arbiter shares a single event output port between all channels, using a valid/ready handshake.
- Sits between the board buttons and the command/FSM logic that consumes button events.

Parameters:
- N, 4, number of button channels (2..16).
- DEB_CYCLES, 4, consecutive stable synchronised samples required before the debounced level changes (>=1).
- ID_W, $clog2(N), width of evt_id. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  N  raw asynchronous button levels, active high.
- evt_ready  input  1  consumer accepts the event this cycle.
- evt_valid  output  1  an event is presented on evt_id.
- evt_id  output  ID_W  index of the channel whose press is presented.
- drop_clr  input  1  synchronous clear of drop_flag (all bits).
- drop_flag  output  N  sticky: a press on channel i was lost because one was already pending.

Behaviour:
- Reset (async, rst_n=0): all of the following go to 0 immediately:
  - synchroniser flops, debounced levels, delayed levels, debounce counters;
  - pending[N-1:0], rr_ptr, evt_valid, evt_id, drop_flag.
  - Buttons held high during reset produce one event after release of reset plus the normal latency.
- Synchroniser: 2 flops per channel.
- Debounce, per channel:
  - cnt counts consecutive cycles in which the synchronised level differs from the debounced level deb.
  - cnt clears whenever they match.
  - When the levels differ and cnt==DEB_CYCLES-1, deb toggles and cnt clears.
  - Glitches shorter than DEB_CYCLES synchronised samples are ignored.
- Edge detect:
  - deb_d is deb delayed by one cycle.
  - press[i] = deb & ~deb_d, a single-cycle pulse. Falling edges produce nothing.
- Latency:
  - Let edge k be the first clk edge that samples btn_in[i] high.
  - Then pending[i] is set at edge k+DEB_CYCLES+2.
  - evt_valid rises at edge k+DEB_CYCLES+3 if the output register is free.
  - With DEB_CYCLES=4 this is 7 cycles.
- Pending, per channel:
  - Set by press[i]; cleared when channel i is loaded into the output register.
  - Load and new press on the same cycle: pending stays 1 (the new press is kept).
  - Press while pending[i]=1 and not loaded that cycle: press lost, drop_flag[i] set.
- drop_flag:
  - drop_clr=1 clears all bits.
  - A set on the same cycle as drop_clr wins (the bit stays 1).
- Output register, a 2-state FSM:
  - IDLE (evt_valid=0). If any pending bit is set: load the winner into evt_id, evt_valid=1, go to FULL.
  - FULL (evt_valid=1). evt_id is held stable while evt_ready=0.
  - FULL with evt_ready=1: the event is consumed that edge. If another pending bit is set (excluding one being set that same cycle by press), load the next winner back-to-back and stay FULL. Otherwise go to IDLE.
  - Throughput: 1 event/cycle while evt_ready=1.
- Round-robin arbitration:
  - Search pending starting at index rr_ptr, wrapping N-1 to 0.
  - The first set bit wins.
  - On load, rr_ptr = winner+1 mod N.
  - rr_ptr does not move when nothing is loaded.
- Reset mid-handshake: the event is discarded, all pending is cleared, and no event is emitted after reset except for buttons still held.

Decomposition:
- Shared package btn_pkg holds:
  - constant N_BTN=4 and DEB_CYCLES_DEFAULT=4;
  - typedef of the FSM state enum {ST_IDLE, ST_FULL}.
- Sub-module btn_conditioner (1 channel: synchroniser, debounce counter, deb/deb_d, press output) is instantiated N times via generate.
- Arbiter, pending flags, drop flags and output FSM live in the top level.

Test Plan:
- Reset, then btn_in[2] held high from edge k, evt_ready=1, DEB_CYCLES=4 -> evt_valid=1 with evt_id=2 at edge k+7 for exactly 1 cycle; no further event while held or on release.
- Glitch: btn_in[0] high for 3 cycles then low -> no event, pending stays 0.
- btn_in[0], btn_in[1], btn_in[3] rise on the same cycle, evt_ready=1, rr_ptr=0 -> events 0, 1, 3 on consecutive cycles; rr_ptr ends at 0.
- evt_ready=0 with event id 1 presented for 10 cycles, then a second debounced press on channel 1 -> evt_id stays 1, pending[1]=1 stays set, drop_flag=0. A third press before acceptance -> drop_flag[1]=1. drop_clr pulse -> drop_flag=0.
- rr_ptr=2 with pending=4'b0011 -> event 0 then event 1 (wrap-around); rr_ptr ends at 2.
- rst_n asserted low while evt_valid=1 and evt_ready=0 -> evt_valid=0, evt_id=0, pending=0 immediately without waiting for clk; no event after rst_n returns high with all buttons released.
